// File: rtl/axi4_arb_pkg.sv
// Shared types and constants for the two-requester AXI4 read arbiter.
package axi4_arb_pkg;

  // AR-stage FSM: IDLE arbitrates, HOLD presents the captured request downstream
  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } arb_state_e;

  // Requester index (0 or 1); also the MSB of the manager-side ID
  typedef logic [0:0] req_idx_t;

  // AXI4 ARBURST encodings
  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  // Outstanding counters cover limits up to 15
  localparam int CNT_WIDTH = 4;

endpackage

// File: rtl/axi4_outstanding_ctr.sv
// Per-requester outstanding read-burst counter with saturation at both ends.
module axi4_outstanding_ctr
  import axi4_arb_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 inc,
  input  logic                 dec,
  input  logic [CNT_WIDTH-1:0] limit,
  output logic [CNT_WIDTH-1:0] count,
  output logic                 at_limit
);

  logic [CNT_WIDTH-1:0] count_r;

  // Count issued bursts up and completed bursts (last beat) down
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_r <= {CNT_WIDTH{1'b0}};
    end else begin
      case ({inc, dec})
        2'b10: begin
          if (count_r != {CNT_WIDTH{1'b1}}) begin
            count_r <= count_r + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
          end
        end
        2'b01: begin
          // a stray last beat at zero must not wrap the counter
          if (count_r != {CNT_WIDTH{1'b0}}) begin
            count_r <= count_r - {{(CNT_WIDTH-1){1'b0}}, 1'b1};
          end
        end
        default: count_r <= count_r;
      endcase
    end
  end

  assign count    = count_r;
  assign at_limit = (count_r >= limit);

endmodule

// File: rtl/axi4_read_arbiter2.sv
// Two-requester AXI4 read arbiter: round-robin AR stage with a holding
// register, combinational R routing by manager ID MSB, outstanding tracking.
module axi4_read_arbiter2
  import axi4_arb_pkg::*;
#(
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int ID_WIDTH        = 4,
  parameter int MAX_OUTSTANDING = 8
) (
  input  logic                  ACLK,
  input  logic                  ARESET,
  input  logic                  s0_arvalid,
  input  logic [ADDR_WIDTH-1:0] s0_araddr,
  input  logic [7:0]            s0_arlen,
  input  logic [2:0]            s0_arsize,
  input  logic [1:0]            s0_arburst,
  input  logic [ID_WIDTH-1:0]   s0_arid,
  output logic                  s0_arready,
  output logic                  s0_rvalid,
  output logic [DATA_WIDTH-1:0] s0_rdata,
  output logic [1:0]            s0_rresp,
  output logic                  s0_rlast,
  output logic [ID_WIDTH-1:0]   s0_rid,
  input  logic                  s0_rready,
  input  logic                  s1_arvalid,
  input  logic [ADDR_WIDTH-1:0] s1_araddr,
  input  logic [7:0]            s1_arlen,
  input  logic [2:0]            s1_arsize,
  input  logic [1:0]            s1_arburst,
  input  logic [ID_WIDTH-1:0]   s1_arid,
  output logic                  s1_arready,
  output logic                  s1_rvalid,
  output logic [DATA_WIDTH-1:0] s1_rdata,
  output logic [1:0]            s1_rresp,
  output logic                  s1_rlast,
  output logic [ID_WIDTH-1:0]   s1_rid,
  input  logic                  s1_rready,
  output logic                  m_arvalid,
  output logic [ADDR_WIDTH-1:0] m_araddr,
  output logic [7:0]            m_arlen,
  output logic [2:0]            m_arsize,
  output logic [1:0]            m_arburst,
  output logic [ID_WIDTH:0]     m_arid,
  input  logic                  m_arready,
  input  logic                  m_rvalid,
  input  logic [DATA_WIDTH-1:0] m_rdata,
  input  logic [1:0]            m_rresp,
  input  logic                  m_rlast,
  input  logic [ID_WIDTH:0]     m_rid,
  output logic                  m_rready,
  output logic                  s0_busy,
  output logic                  s1_busy
);

  localparam logic [CNT_WIDTH-1:0] LIMIT = CNT_WIDTH'(MAX_OUTSTANDING);

  arb_state_e            state_r;
  req_idx_t              last_grant_r;
  logic [ADDR_WIDTH-1:0] addr_r;
  logic [7:0]            len_r;
  logic [2:0]            size_r;
  logic [1:0]            burst_r;
  logic [ID_WIDTH:0]     id_r;

  req_idx_t              grant_s;
  logic                  grant_valid_s;
  logic                  elig0_s, elig1_s;
  logic                  at_limit0_s, at_limit1_s;
  logic [CNT_WIDTH-1:0]  count0_s, count1_s;
  logic                  r_sel_s;
  logic                  r_done0_s, r_done1_s;

  assign elig0_s = s0_arvalid & ~at_limit0_s;
  assign elig1_s = s1_arvalid & ~at_limit1_s;

  // Pick the requester to accept this cycle; contention goes to the non-last grant
  always_comb begin
    grant_valid_s = 1'b0;
    grant_s       = 1'b0;
    if (state_r == ST_IDLE) begin
      if (elig0_s && elig1_s) begin
        grant_valid_s = 1'b1;
        grant_s       = ~last_grant_r;
      end else if (elig0_s) begin
        grant_valid_s = 1'b1;
        grant_s       = 1'b0;
      end else if (elig1_s) begin
        grant_valid_s = 1'b1;
        grant_s       = 1'b1;
      end else begin
        grant_valid_s = 1'b0;
        grant_s       = 1'b0;
      end
    end else begin
      grant_valid_s = 1'b0;
      grant_s       = 1'b0;
    end
  end

  assign s0_arready = grant_valid_s & (grant_s == 1'b0);
  assign s1_arready = grant_valid_s & (grant_s == 1'b1);

  // AR FSM: capture the granted request, then hold it until the manager accepts
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_r      <= ST_IDLE;
      last_grant_r <= 1'b1;
      addr_r       <= {ADDR_WIDTH{1'b0}};
      len_r        <= 8'h00;
      size_r       <= 3'b000;
      burst_r      <= 2'b00;
      id_r         <= {(ID_WIDTH+1){1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (grant_valid_s) begin
            state_r      <= ST_HOLD;
            last_grant_r <= grant_s;
            addr_r       <= grant_s ? s1_araddr  : s0_araddr;
            len_r        <= grant_s ? s1_arlen   : s0_arlen;
            size_r       <= grant_s ? s1_arsize  : s0_arsize;
            burst_r      <= grant_s ? s1_arburst : s0_arburst;
            id_r         <= {grant_s, (grant_s ? s1_arid : s0_arid)};
          end
        end
        ST_HOLD: begin
          if (m_arready) begin
            state_r <= ST_IDLE;
          end
        end
        default: state_r <= ST_IDLE;
      endcase
    end
  end

  assign m_arvalid = (state_r == ST_HOLD);
  assign m_araddr  = addr_r;
  assign m_arlen   = len_r;
  assign m_arsize  = size_r;
  assign m_arburst = burst_r;
  assign m_arid    = id_r;

  // R path: steer the beat to the requester named by the ID MSB
  assign r_sel_s   = m_rid[ID_WIDTH];
  assign s0_rvalid = m_rvalid & ~r_sel_s;
  assign s1_rvalid = m_rvalid &  r_sel_s;
  assign s0_rdata  = m_rdata;
  assign s1_rdata  = m_rdata;
  assign s0_rresp  = m_rresp;
  assign s1_rresp  = m_rresp;
  assign s0_rlast  = m_rlast;
  assign s1_rlast  = m_rlast;
  assign s0_rid    = m_rid[ID_WIDTH-1:0];
  assign s1_rid    = m_rid[ID_WIDTH-1:0];
  assign m_rready  = r_sel_s ? s1_rready : s0_rready;

  assign r_done0_s = m_rvalid & m_rready & m_rlast & ~r_sel_s;
  assign r_done1_s = m_rvalid & m_rready & m_rlast &  r_sel_s;

  axi4_outstanding_ctr u_ctr0 (
    .clk      (ACLK),
    .rst      (ARESET),
    .inc      (s0_arready),
    .dec      (r_done0_s),
    .limit    (LIMIT),
    .count    (count0_s),
    .at_limit (at_limit0_s)
  );

  axi4_outstanding_ctr u_ctr1 (
    .clk      (ACLK),
    .rst      (ARESET),
    .inc      (s1_arready),
    .dec      (r_done1_s),
    .limit    (LIMIT),
    .count    (count1_s),
    .at_limit (at_limit1_s)
  );

  assign s0_busy = (count0_s != {CNT_WIDTH{1'b0}});
  assign s1_busy = (count1_s != {CNT_WIDTH{1'b0}});

endmodule
